fft_frame_scheduler: RTL and testbench

//  Shares one FFT+serializer pipeline (fft_fp -> serializer) among NREQ frame requesters.

---
 rtl/fft_sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/fft_frame_scheduler.sv | 126 ++++++++++++
 tb/tb_fft_frame_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sched_pkg.sv
// Shared state encoding and sizing helpers for the FFT frame scheduler.
package fft_sched_pkg;

    localparam int FRAME_CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_RELEASE
    } state_e;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i,
// searching cyclically; returns a one-hot grant and its index.
module rr_arbiter
    import fft_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]       req_i,
    input  logic [id_w(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [id_w(NREQ)-1:0] idx_o
);

    localparam int ID_W = id_w(NREQ);

    int   j;
    logic hit;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        hit   = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!hit && req_i[j]) begin
                hit      = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Round-robin owner of a shared FFT+serializer pipeline for NREQ requesters.
// Optional WAIT watchdog with abort/err: define FFT_SCHED_TIMEOUT_EN.
module fft_frame_scheduler
    import fft_sched_pkg::*;
#(
    parameter int N         = 8,
    parameter int WORD_SIZE = 32,
    parameter int NREQ      = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*N*WORD_SIZE-1:0]   frame_in,
    output logic [NREQ-1:0]               ack,
    output logic                          err,
    output logic [N*WORD_SIZE-1:0]        pipe_data,
    output logic                          pipe_start,
    input  logic                          pipe_done,
    output logic [id_w(NREQ)-1:0]         pipe_id,
    output logic                          busy,
    output logic [FRAME_CNT_W-1:0]        frame_cnt
);

    localparam int PIO_SIZE = N * WORD_SIZE;
    localparam int ID_W     = id_w(NREQ);

    if (NREQ < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("fft_frame_scheduler: need NREQ >= 2 and TIMEOUT >= 1");
    end

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        grant_q;
    logic [ID_W-1:0]        ptr_q;
    logic [ID_W-1:0]        id_q;
    logic [PIO_SIZE-1:0]    data_q;
    logic                   start_q;
    logic [FRAME_CNT_W-1:0] cnt_q;
    logic [NREQ-1:0]        arb_gnt;
    logic [ID_W-1:0]        arb_idx;
    logic                   abort;
    logic                   err_now;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

`ifdef FFT_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    assign abort = (state_q == S_WAIT) && !pipe_done
                && (tmo_q == TMO_W'(TIMEOUT - 1));

    // err_q holds whether the last WAIT cycle ended by watchdog
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else if (state_q == S_WAIT) begin
            tmo_q <= tmo_q + 1'b1;
            err_q <= abort;
        end else begin
            tmo_q <= '0;
        end
    end

    assign err_now = (state_q == S_RELEASE) && err_q;
`else
    assign abort   = 1'b0;
    assign err_now = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ack     = '0;
        unique case (state_q)
            S_IDLE:    if (|arb_gnt) state_d = S_LOAD;
            S_LOAD:    state_d = S_START;
            S_START:   state_d = S_WAIT;
            S_WAIT:    if (pipe_done || abort) state_d = S_RELEASE;
            S_RELEASE: begin
                ack[id_q] = 1'b1;
                state_d   = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= (state_q == S_START);
            if (state_q == S_IDLE) grant_q <= arb_idx;
            if (state_q == S_LOAD) begin
                data_q <= frame_in[int'(grant_q)*PIO_SIZE +: PIO_SIZE];
                id_q   <= grant_q;
            end
            if (state_q == S_RELEASE) begin
                ptr_q <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
                if (!err_now) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign pipe_data  = data_q;
    assign pipe_id    = id_q;
    assign pipe_start = start_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_cnt  = cnt_q;
    assign err        = err_now;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler: grant-order table, latency,
// reset-in-WAIT and (with FFT_SCHED_TIMEOUT_EN) watchdog abort.
`timescale 1ns/1ps
module tb_fft_frame_scheduler;

    localparam int N    = 8;
    localparam int WS   = 32;
    localparam int NREQ = 4;
    localparam int TMO  = 16;
    localparam int PIO  = N * WS;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*PIO-1:0]   frame_in;
    logic [NREQ-1:0]       ack;
    logic                  err;
    logic [PIO-1:0]        pipe_data;
    logic                  pipe_start;
    logic                  pipe_done = 1'b0;
    logic [1:0]            pipe_id;
    logic                  busy;
    logic [15:0]           frame_cnt;

    always #5 clk = ~clk;

    fft_frame_scheduler #(
        .N(N), .WORD_SIZE(WS), .NREQ(NREQ), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .frame_in(frame_in),
        .ack(ack), .err(err), .pipe_data(pipe_data),
        .pipe_start(pipe_start), .pipe_done(pipe_done),
        .pipe_id(pipe_id), .busy(busy), .frame_cnt(frame_cnt)
    );

    typedef struct {
        logic [3:0] mask;
        logic [1:0] id;
    } vec_t;

    typedef struct {
        logic [1:0]     id;
        logic [PIO-1:0] data;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           mon_e;
    logic [PIO-1:0] frames[NREQ];
    logic [1:0]     cur_id = '0;
    logic [PIO-1:0] cur_data = '0;
    logic           exp_err = 1'b0;
    int             tests = 0;
    int             fails = 0;
    int             cyc = 0;
    int             ack_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] oh(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    task automatic chk(input string nm, input logic [PIO-1:0] act,
                       input logic [PIO-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every pipe_start consumes one expected grant
    always @(negedge clk) begin
        if (reset_n) begin
            if (pipe_start) begin
                chk("ack_with_start", PIO'(ack), '0);
                if (exp_q.size() == 0) begin
                    chk("spurious_start", PIO'(exp_q.size()), PIO'(1));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("grant_id", PIO'(pipe_id), PIO'(mon_e.id));
                    chk("pipe_data", pipe_data, mon_e.data);
                    cur_id   = mon_e.id;
                    cur_data = mon_e.data;
                end
            end
            if (ack != '0) begin
                chk("ack_onehot", PIO'(ack), PIO'(oh(cur_id)));
                chk("ack_err", PIO'(err), PIO'(exp_err));
                chk("data_held", pipe_data, cur_data);
                chk("id_at_ack", PIO'(pipe_id), PIO'(cur_id));
            end
        end
    end

    task automatic run_frame(input logic [3:0] mask, input logic [1:0] id,
                             input int dly, input bit gap, output int lat);
        exp_t e;
        int   n;
        int   s;
        e.id   = id;
        e.data = frames[id];
        exp_q.push_back(e);
        req = mask;
        n   = 0;
        while (!pipe_start && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        lat = n;
        chk("start_seen", PIO'(pipe_start), PIO'(1));
        s = cyc;
        if (gap) chk("ack_to_start", PIO'(s - ack_cyc), PIO'(4));
        if (dly > 0) begin
            @(posedge clk); #1;
            chk("start_pulse", PIO'(pipe_start), '0);
            repeat (dly - 1) @(posedge clk);
            #1;
        end
        pipe_done = 1'b1;
        @(posedge clk); #1;
        pipe_done = 1'b0;
        chk("done_to_ack", PIO'(ack), PIO'(oh(id)));
        ack_cyc = cyc;
        @(posedge clk); #1;
        chk("ack_one_cycle", PIO'(ack), '0);
    endtask

    vec_t vecs[9];

    initial begin
        int lat;
        int n;

        vecs[0] = '{4'b1111, 2'd1};
        vecs[1] = '{4'b1111, 2'd2};
        vecs[2] = '{4'b1111, 2'd3};
        vecs[3] = '{4'b1111, 2'd0};
        vecs[4] = '{4'b0101, 2'd2};
        vecs[5] = '{4'b0001, 2'd0};
        vecs[6] = '{4'b1010, 2'd1};
        vecs[7] = '{4'b1010, 2'd3};
        vecs[8] = '{4'b1100, 2'd2};

        frames[0] = {32{8'hAA}};
        for (int i = 1; i < NREQ; i++)
            for (int w = 0; w < N; w++)
                frames[i][w*WS +: WS] = $urandom;
        for (int i = 0; i < NREQ; i++)
            frame_in[i*PIO +: PIO] = frames[i];

        // Reset and 20 idle cycles with no requests
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", PIO'(busy), '0);
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("idle_ctl", PIO'({busy, pipe_start, ack, err, pipe_id, frame_cnt}), '0);
            chk("idle_data", pipe_data, '0);
        end

        // pipe_done while idle must be ignored
        pipe_done = 1'b1;
        @(posedge clk); #1;
        pipe_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("idle_done_ignored", PIO'({busy, ack}), '0);
            @(posedge clk); #1;
        end

        // Single requester, long pipeline
        run_frame(4'b0001, 2'd0, 50, 1'b0, lat);
        chk("req_to_start_lat", PIO'(lat), PIO'(3));
        chk("frame_cnt_1", PIO'(frame_cnt), PIO'(1));

        // Round-robin table
        for (int v = 0; v < 9; v++) begin
            run_frame(vecs[v].mask, vecs[v].id, 2 + v, v != 0, lat);
            chk("tbl_lat", PIO'(lat), PIO'(3));
        end
        req = '0;
        chk("frame_cnt_10", PIO'(frame_cnt), PIO'(10));

        // Reset during WAIT: no ack, outputs cleared, then re-arbitrate
        exp_q.push_back('{2'd1, frames[1]});
        req = 4'b0010;
        n = 0;
        while (!pipe_start && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_test_start", PIO'(pipe_start), PIO'(1));
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_ctl", PIO'({busy, pipe_start, ack, err, pipe_id, frame_cnt}), '0);
        chk("rst_data", pipe_data, '0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_no_ack", PIO'(ack), '0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_frame(4'b0010, 2'd1, 6, 1'b0, lat);
        chk("post_rst_lat", PIO'(lat), PIO'(3));
        chk("post_rst_cnt", PIO'(frame_cnt), PIO'(1));
        req = '0;

`ifdef FFT_SCHED_TIMEOUT_EN
        // Watchdog abort: ack+err after TMO WAIT cycles, count unchanged
        exp_err = 1'b1;
        exp_q.push_back('{2'd0, frames[0]});
        req = 4'b0001;
        n = 0;
        while (!pipe_start && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tmo_start", PIO'(pipe_start), PIO'(1));
        lat = cyc;
        n = 0;
        while (ack == '0 && n < 4 * TMO) begin
            @(posedge clk); #1;
            n++;
        end
        req = '0;
        chk("tmo_ack", PIO'(ack), PIO'(4'b0001));
        chk("tmo_err", PIO'(err), PIO'(1));
        chk("tmo_cycles", PIO'(cyc - lat), PIO'(TMO));
        @(posedge clk); #1;
        exp_err = 1'b0;
        chk("tmo_cnt_same", PIO'(frame_cnt), PIO'(1));
        pipe_done = 1'b1;
        @(posedge clk); #1;
        pipe_done = 1'b0;
        repeat (3) begin
            chk("late_done_ignored", PIO'({busy, ack, err}), '0);
            @(posedge clk); #1;
        end
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", PIO'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
